pcileech_tlps128_rr_arbiter: RTL and testbench
==============================================

PCILEECH_TLPS128_RR_ARBITER -- requirements
Module: pcileech_tlps128_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4: number of 128-bit TLP sources (cfg response, BAR response, TX, spare).
REQ-002 SHALL have parameter CNT_W, default 16: width of each per-source packet counter.
REQ-003 SHALL be one clock and one reset: clk_pcie drives all state; rst is synchronous and active-high.
REQ-004 clk_pcie  input  1  PCIe user clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 src_en  input  NUM_SRC  per-source arbitration enable.
REQ-007 s_tdata  input  NUM_SRC x 128  source TLP data.
REQ-008 s_tkeepdw  input  NUM_SRC x 4  source DWORD keep.
REQ-009 s_tuser  input  NUM_SRC x 9  source sideband, passed through unchanged.
REQ-010 s_tlast / s_tvalid  input  NUM_SRC each  source end-of-packet / valid.
REQ-011 s_tready  output  NUM_SRC  source ready.
REQ-012 m_tdata 128, m_tkeepdw 4, m_tuser 9, m_tlast 1, m_tvalid 1  output  sink beat.
REQ-013 m_tready  input  1  sink ready.
REQ-014 cur_grant  output  clog2(NUM_SRC)  granted source index; busy  output  1  packet in flight.
REQ-015 pkt_cnt  output  NUM_SRC x CNT_W  completed packets per source.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and XFER.
REQ-017 IDLE: m_tvalid=0 and all s_tready=0; if any source has s_tvalid&src_en, the next such index after last_grant (cyclic order) is registered into cur_grant and the FSM enters XFER on the next cycle.
REQ-018 XFER: m_* equal s_*[cur_grant] combinationally; s_tready[cur_grant]=m_tready; every other s_tready=0.
REQ-019 A beat transfers only when m_tvalid&m_tready; data, keep, user and last SHALL pass unmodified.
REQ-020 On a transferred beat with m_tlast=1: FSM returns to IDLE, last_grant<=cur_grant, pkt_cnt[cur_grant] increments by 1.
REQ-021 Arbitration is packet-granular; the grant SHALL NOT change before tlast, even if the granted source drops s_tvalid between beats.
REQ-022 Deasserting src_en during XFER SHALL NOT abort the packet; it excludes that source from later IDLE decisions only.
REQ-023 Each packet costs exactly one IDLE cycle; sustained throughput = beats/(beats+1).
REQ-024 pkt_cnt SHALL wrap from 2^CNT_W-1 to 0 with no saturation or flag.
REQ-025 busy=1 exactly while in XFER.
REQ-026 Single-beat packets (tlast on first beat) SHALL be supported.

Reset
REQ-027 On rst: FSM=IDLE, cur_grant=0, last_grant=NUM_SRC-1 (source 0 wins first), pkt_cnt all 0, m_tvalid=0, s_tready=0.
REQ-028 rst during XFER SHALL drop the in-flight packet immediately without completing it or counting it; sink-side truncation is acceptable and owned by upstream reset.

Structure
REQ-029 Shared package pcileech_tlps128_arb_pkg SHALL hold the FSM state enum, the default NUM_SRC, and the constants 128 (data), 4 (keep) and 9 (user).
REQ-030 Sub-module pcileech_rr_pick SHALL be the combinational picker: inputs request vector and last_grant; outputs next index and a found flag.

Verification
REQ-031 After reset, sources 0..3 each hold one 2-beat packet -> output order 0,1,2,3; each packet preceded by one IDLE cycle; pkt_cnt = 1,1,1,1.
REQ-032 Source 1 sends a 3-beat packet while m_tready toggles 1,0,1,0,1 -> beats out in order and unchanged, s_tready[1] mirrors m_tready, others remain 0.
REQ-033 Source 2 drops s_tvalid for 5 cycles mid-packet while source 0 is valid -> grant remains 2 until its tlast, then source 0.
REQ-034 src_en=4'b1011 with all sources valid -> source 2 never granted; pkt_cnt[2] stays 0.
REQ-035 Preload pkt_cnt[0] to 16'hFFFF by sending 65535 single-beat packets, then one more -> pkt_cnt[0]=0.
REQ-036 rst asserted on the 2nd beat of a 4-beat packet -> next cycle m_tvalid=0, busy=0, counters 0; after release source 0 is granted first.

Source files
------------

// File: rtl/pcileech_tlps128_arb_pkg.sv
// Shared types and widths for the 128-bit TLP round-robin arbiter.
package pcileech_tlps128_arb_pkg;

  localparam int ARB_NUM_SRC = 4;
  localparam int TLP_DATA_W  = 128;
  localparam int TLP_KEEP_W  = 4;
  localparam int TLP_USER_W  = 9;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/pcileech_rr_pick.sv
// Combinational round-robin picker: first requesting index after last_grant, cyclically.
module pcileech_rr_pick
  import pcileech_tlps128_arb_pkg::*;
#(
  parameter int NUM_SRC = ARB_NUM_SRC,
  parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   next_idx,
  output logic               found
);

  logic [IDX_W-1:0] cand [NUM_SRC];

  // cand[gi] is the index visited (gi+1) steps after last_grant, wrapped into range
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum = {1'b0, last_grant} + (IDX_W+1)'(gi + 1);
      assign cand[gi] = (sum >= (IDX_W+1)'(NUM_SRC)) ? IDX_W'(sum - (IDX_W+1)'(NUM_SRC))
                                                      : sum[IDX_W-1:0];
    end
  endgenerate

  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        next_idx = cand[i];
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcileech_tlps128_rr_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_SRC 128-bit TLP streams onto one sink,
// with one IDLE decision cycle per packet and a wrapping completed-packet counter per source.
module pcileech_tlps128_rr_arbiter
  import pcileech_tlps128_arb_pkg::*;
#(
  parameter int NUM_SRC = ARB_NUM_SRC,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                         clk_pcie,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           src_en,
  input  logic [NUM_SRC*TLP_DATA_W-1:0] s_tdata,
  input  logic [NUM_SRC*TLP_KEEP_W-1:0] s_tkeepdw,
  input  logic [NUM_SRC*TLP_USER_W-1:0] s_tuser,
  input  logic [NUM_SRC-1:0]           s_tlast,
  input  logic [NUM_SRC-1:0]           s_tvalid,
  output logic [NUM_SRC-1:0]           s_tready,
  output logic [TLP_DATA_W-1:0]        m_tdata,
  output logic [TLP_KEEP_W-1:0]        m_tkeepdw,
  output logic [TLP_USER_W-1:0]        m_tuser,
  output logic                         m_tlast,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [IDX_W-1:0]             cur_grant,
  output logic                         busy,
  output logic [NUM_SRC*CNT_W-1:0]     pkt_cnt
);

  arb_state_e       state_reg, state_next;
  logic [IDX_W-1:0] cur_grant_reg, cur_grant_next;
  logic [IDX_W-1:0] last_grant_reg, last_grant_next;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             pkt_done;

  logic [TLP_DATA_W-1:0] src_data [NUM_SRC];
  logic [TLP_KEEP_W-1:0] src_keep [NUM_SRC];
  logic [TLP_USER_W-1:0] src_user [NUM_SRC];
  logic [CNT_W-1:0]      cnt_reg  [NUM_SRC];

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_data[gi] = s_tdata[gi*TLP_DATA_W +: TLP_DATA_W];
      assign src_keep[gi] = s_tkeepdw[gi*TLP_KEEP_W +: TLP_KEEP_W];
      assign src_user[gi] = s_tuser[gi*TLP_USER_W +: TLP_USER_W];
      assign s_tready[gi] = (state_reg == ARB_XFER) && (cur_grant_reg == IDX_W'(gi)) && m_tready;
      assign pkt_cnt[gi*CNT_W +: CNT_W] = cnt_reg[gi];

      always_ff @(posedge clk_pcie) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (pkt_done && (cur_grant_reg == IDX_W'(gi))) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  // src_en only gates new grants; an in-flight packet runs to tlast regardless
  pcileech_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (s_tvalid & src_en),
    .last_grant (last_grant_reg),
    .next_idx   (pick_idx),
    .found      (pick_found)
  );

  always_comb begin
    m_tdata   = '0;
    m_tkeepdw = '0;
    m_tuser   = '0;
    m_tlast   = 1'b0;
    m_tvalid  = 1'b0;
    if (state_reg == ARB_XFER) begin
      m_tdata   = src_data[cur_grant_reg];
      m_tkeepdw = src_keep[cur_grant_reg];
      m_tuser   = src_user[cur_grant_reg];
      m_tlast   = s_tlast[cur_grant_reg];
      m_tvalid  = s_tvalid[cur_grant_reg];
    end
    pkt_done = m_tvalid && m_tready && m_tlast;
  end

  always_comb begin
    state_next      = state_reg;
    cur_grant_next  = cur_grant_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (pick_found) begin
          cur_grant_next = pick_idx;
          state_next     = ARB_XFER;
        end
      end
      ARB_XFER: begin
        if (pkt_done) begin
          last_grant_next = cur_grant_reg;
          state_next      = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // last_grant starts at the top index so source 0 wins the first decision
  always_ff @(posedge clk_pcie) begin
    if (rst) begin
      state_reg      <= ARB_IDLE;
      cur_grant_reg  <= '0;
      last_grant_reg <= IDX_W'(NUM_SRC - 1);
    end else begin
      state_reg      <= state_next;
      cur_grant_reg  <= cur_grant_next;
      last_grant_reg <= last_grant_next;
    end
  end

  assign cur_grant = cur_grant_reg;
  assign busy      = (state_reg == ARB_XFER);

endmodule

// File: tb/tb_pcileech_tlps128_rr_arbiter.sv
// Self-checking bench: per-cycle compare against a packet-level model plus directed literal checks.
module tb_pcileech_tlps128_rr_arbiter;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int DW = 128;
  localparam int KW = 4;
  localparam int UW = 9;

  logic              clk_pcie = 1'b0;
  logic              rst      = 1'b1;
  logic [N-1:0]      src_en   = '1;
  logic [N*DW-1:0]   s_tdata;
  logic [N*KW-1:0]   s_tkeepdw;
  logic [N*UW-1:0]   s_tuser;
  logic [N-1:0]      s_tlast, s_tvalid, s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeepdw;
  logic [UW-1:0]     m_tuser;
  logic              m_tlast, m_tvalid;
  logic              m_tready = 1'b1;
  logic [1:0]        cur_grant;
  logic              busy;
  logic [N*CW-1:0]   pkt_cnt;

  always #5 clk_pcie = ~clk_pcie;

  pcileech_tlps128_rr_arbiter #(.NUM_SRC(N), .CNT_W(CW)) dut (
    .clk_pcie (clk_pcie), .rst (rst), .src_en (src_en),
    .s_tdata (s_tdata), .s_tkeepdw (s_tkeepdw), .s_tuser (s_tuser),
    .s_tlast (s_tlast), .s_tvalid (s_tvalid), .s_tready (s_tready),
    .m_tdata (m_tdata), .m_tkeepdw (m_tkeepdw), .m_tuser (m_tuser),
    .m_tlast (m_tlast), .m_tvalid (m_tvalid), .m_tready (m_tready),
    .cur_grant (cur_grant), .busy (busy), .pkt_cnt (pkt_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- source stimulus: packets of plen beats, optional mid-packet gap
  int pkts_left[N], plen[N], beat_idx[N], pkt_no[N], gap_at[N], gap_len[N], stall[N];

  always_comb begin
    s_tdata   = '0;
    s_tkeepdw = '0;
    s_tuser   = '0;
    s_tlast   = '0;
    s_tvalid  = '0;
    for (int i = 0; i < N; i++) begin
      s_tvalid[i] = (pkts_left[i] > 0) && (stall[i] == 0);
      s_tlast[i]  = (beat_idx[i] == plen[i] - 1);
      s_tdata[i*DW +: DW] = {8'(i), 16'(pkt_no[i]), 8'(beat_idx[i]),
                             {3{32'(i*1000 + pkt_no[i]*16 + beat_idx[i]) ^ 32'h5A5AC3C3}}};
      s_tkeepdw[i*KW +: KW] = 4'(beat_idx[i] + i + 1);
      s_tuser[i*UW +: UW]   = 9'(i*37 + beat_idx[i]*5 + pkt_no[i]);
    end
  end

  always @(posedge clk_pcie) begin
    for (int i = 0; i < N; i++) begin
      if (s_tvalid[i] && s_tready[i]) begin
        if (beat_idx[i] == plen[i] - 1) begin
          beat_idx[i]  <= 0;
          pkts_left[i] <= pkts_left[i] - 1;
          pkt_no[i]    <= pkt_no[i] + 1;
        end else begin
          beat_idx[i] <= beat_idx[i] + 1;
          if (beat_idx[i] + 1 == gap_at[i]) stall[i] <= gap_len[i];
        end
      end else if (stall[i] > 0) begin
        stall[i] <= stall[i] - 1;
      end
    end
  end

  int rdy_mode = 0;
  always @(posedge clk_pcie) m_tready <= (rdy_mode == 1) ? ~m_tready : 1'b1;

  // ---------------- observation of DUT handshakes
  int done_pkts = 0;
  int pkt_order[$];
  int beat_log[$];

  always @(posedge clk_pcie) begin
    if (!rst && m_tvalid && m_tready) begin
      beat_log.push_back(int'(m_tdata[103:96]));
      if (m_tlast) begin
        pkt_order.push_back(int'(cur_grant));
        done_pkts <= done_pkts + 1;
      end
    end
  end

  // ---------------- packet-level model: who owns the bus, who went last, how many packets each
  int mdl_owner = -1;
  int mdl_last  = N - 1;
  int mdl_cnt[N];

  function automatic int model_pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk_pcie) begin
    if (rst) begin
      mdl_owner <= -1;
      mdl_last  <= N - 1;
      for (int i = 0; i < N; i++) mdl_cnt[i] <= 0;
    end else if (mdl_owner < 0) begin
      mdl_owner <= model_pick(s_tvalid & src_en, mdl_last);
    end else if (s_tvalid[mdl_owner] && m_tready && s_tlast[mdl_owner]) begin
      mdl_cnt[mdl_owner] <= (mdl_cnt[mdl_owner] + 1) % (1 << CW);
      mdl_last  <= mdl_owner;
      mdl_owner <= -1;
    end
  end

  task automatic compare_cycle();
    logic [N*CW-1:0] exp_cnt;
    logic [N-1:0]    exp_rdy;
    logic            exp_v;
    int              o;
    o = mdl_owner;
    for (int i = 0; i < N; i++) exp_cnt[i*CW +: CW] = CW'(mdl_cnt[i]);
    exp_v   = (o >= 0) ? s_tvalid[o] : 1'b0;
    exp_rdy = (o >= 0 && m_tready) ? (N'(1) << o) : '0;
    check("busy", 128'(busy), 128'(o >= 0));
    check("m_tvalid", 128'(m_tvalid), 128'(exp_v));
    check("s_tready", 128'(s_tready), 128'(exp_rdy));
    check("pkt_cnt", 128'(pkt_cnt), 128'(exp_cnt));
    if (o >= 0) check("cur_grant", 128'(cur_grant), 128'(o));
    if (exp_v) begin
      check("m_tdata", m_tdata, s_tdata[o*DW +: DW]);
      check("m_side", 128'({m_tkeepdw, m_tuser, m_tlast}),
            128'({s_tkeepdw[o*KW +: KW], s_tuser[o*UW +: UW], s_tlast[o]}));
    end
  endtask

  always @(negedge clk_pcie) compare_cycle();

  // ---------------- directed sequence helpers
  task automatic cfg(input int i, input int pk, input int ln);
    pkts_left[i] = pk;
    plen[i]      = ln;
    beat_idx[i]  = 0;
    stall[i]     = 0;
    gap_at[i]    = 0;
    gap_len[i]   = 0;
  endtask

  task automatic wait_pkts(input int n, input int budget, output int cycles);
    int base;
    base   = done_pkts;
    cycles = 0;
    while ((done_pkts - base) < n && cycles < budget) begin
      @(posedge clk_pcie); #1;
      cycles++;
    end
    check("pkt_wait", 128'((done_pkts - base) >= n), 128'(1));
  endtask

  function automatic int enc(input int q[$]);
    int v = 0;
    foreach (q[i]) v = v * 10 + q[i] + 1;
    return v;
  endfunction

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk_pcie); #1;
    rst = 1'b0;
  endtask

  initial begin
    int cyc;
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk_pcie);
    #1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_m_tvalid", 128'(m_tvalid), 128'(0));
    check("rst_s_tready", 128'(s_tready), 128'(0));
    check("rst_cur_grant", 128'(cur_grant), 128'(0));
    check("rst_pkt_cnt", 128'(pkt_cnt), 128'(0));

    // four 2-beat packets: order 0,1,2,3 at 3 cycles each
    rst = 1'b0;
    for (int i = 0; i < N; i++) cfg(i, 1, 2);
    wait_pkts(4, 60, cyc);
    check("rr_order", 128'(enc(pkt_order)), 128'(1234));
    check("rr_cycles", 128'(cyc), 128'(12));
    check("rr_cnt", 128'(pkt_cnt), 128'(32'h01010101));

    // 3-beat packet from source 1 under a toggling sink ready
    pkt_order.delete();
    beat_log.delete();
    rdy_mode = 1;
    cfg(1, 1, 3);
    wait_pkts(1, 30, cyc);
    check("bp_order", 128'(enc(pkt_order)), 128'(2));
    check("bp_beats", 128'(enc(beat_log)), 128'(123));
    rdy_mode = 0;

    // source 2 stalls 5 cycles mid-packet while source 0 waits
    pkt_order.delete();
    @(posedge clk_pcie); #1;
    cfg(2, 1, 4);
    gap_at[2]  = 2;
    gap_len[2] = 5;
    cfg(0, 1, 2);
    wait_pkts(2, 60, cyc);
    check("gap_order", 128'(enc(pkt_order)), 128'(31));
    check("gap_cycles", 128'(cyc), 128'(13));

    // src_en masks source 2 entirely
    pulse_rst();
    pkt_order.delete();
    src_en = 4'b1011;
    for (int i = 0; i < N; i++) cfg(i, 2, 1);
    wait_pkts(6, 60, cyc);
    check("mask_order", 128'(enc(pkt_order)), 128'(124124));
    check("mask_cnt", 128'(pkt_cnt), 128'(32'h02000202));
    pkts_left[2] = 0;
    src_en = '1;

    // counter wrap at 2^CW
    pulse_rst();
    cfg(0, 255, 1);
    wait_pkts(255, 700, cyc);
    check("wrap_max", 128'(pkt_cnt), 128'(32'h000000FF));
    cfg(0, 1, 1);
    wait_pkts(1, 20, cyc);
    check("wrap_zero", 128'(pkt_cnt), 128'(0));

    // reset lands on the 2nd beat of a 4-beat packet from source 2
    pkt_order.delete();
    beat_log.delete();
    cfg(1, 1, 1);
    cfg(2, 1, 4);
    n = 0;
    while (beat_log.size() < 2 && n < 20) begin
      @(posedge clk_pcie); #1;
      n++;
    end
    check("abort_reach", 128'(beat_log.size()), 128'(2));
    check("abort_pre_cnt", 128'(pkt_cnt), 128'(32'h00000100));
    rst = 1'b1;
    @(posedge clk_pcie); #1;
    check("abort_m_tvalid", 128'(m_tvalid), 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_cnt", 128'(pkt_cnt), 128'(0));
    pkt_order.delete();
    cfg(2, 1, 4);
    cfg(0, 1, 2);
    rst = 1'b0;
    wait_pkts(2, 40, cyc);
    check("abort_order", 128'(enc(pkt_order)), 128'(13));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
